adder_scheduler: RTL and testbench

ADDER_SCHEDULER -- requirements
Module: adder_scheduler

---
 rtl/adder_scheduler.sv | 125 ++++++++++++
 tb/tb_adder_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_scheduler.sv
// rtl/adder_scheduler.sv - two-requester arbiter feeding a serial masked byte-lane adder
// One lane per cycle keeps the datapath to a single 8-bit adder; latency is fixed at 8 cycles.
module adder_scheduler #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [63:0] req0_data,
    input  logic [7:0]  req0_mask,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [63:0] req1_data,
    input  logic [7:0]  req1_mask,
    output logic        req1_ready,
    output logic [7:0]  result,
    output logic        result_valid,
    output logic        result_id,
    input  logic        result_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] data_q, data_d;
    logic [7:0]  mask_q, mask_d;
    logic        id_q, id_d;
    logic [7:0]  acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;

    logic        grant_id;
    logic        accept;
    logic [7:0]  lane;

    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = RR_EN ? ~last_grant_q : 1'b0;
        end else begin
            grant_id = ~req0_valid;
        end

        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_q == IDLE && !reset) begin
            req0_ready = req0_valid & ~grant_id;
            req1_ready = req1_valid & grant_id;
        end
        accept = req0_ready | req1_ready;
    end

    assign lane = data_q[{cnt_q, 3'b000} +: 8];

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        mask_d       = mask_q;
        id_d         = id_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d       = grant_id ? req1_data : req0_data;
                    mask_d       = grant_id ? req1_mask : req0_mask;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    acc_d        = 8'd0;
                    cnt_d        = 3'd0;
                    state_d      = ACCUM;
                end
            end
            ACCUM: begin
                // Carry out of bit 7 is intentionally dropped (modulo-256 sum).
                if (mask_q[cnt_q]) begin
                    acc_d = acc_q + lane;
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            data_q       <= 64'd0;
            mask_q       <= 8'd0;
            id_q         <= 1'b0;
            acc_q        <= 8'd0;
            cnt_q        <= 3'd0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            id_q         <= id_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign result       = acc_q;
    assign result_id    = id_q;
    assign result_valid = (state_q == DONE);
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_adder_scheduler.sv
// tb/tb_adder_scheduler.sv - directed self-checking bench for adder_scheduler
module tb_adder_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [63:0] req0_data, req1_data;
    logic [7:0]  req0_mask, req1_mask;
    logic        result_ready;

    logic        req0_ready, req1_ready, result_valid, result_id, busy;
    logic [7:0]  result;
    logic        fp_req0_ready, fp_req1_ready, fp_result_valid, fp_result_id, fp_busy;
    logic [7:0]  fp_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_scheduler #(.RR_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_mask(req0_mask), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_mask(req1_mask), .req1_ready(req1_ready),
        .result(result), .result_valid(result_valid), .result_id(result_id),
        .result_ready(result_ready), .busy(busy)
    );

    adder_scheduler #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_mask(req0_mask), .req0_ready(fp_req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_mask(req1_mask), .req1_ready(fp_req1_ready),
        .result(fp_result), .result_valid(fp_result_valid), .result_id(fp_result_id),
        .result_ready(result_ready), .busy(fp_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; result_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0; req0_mask = '0; req1_mask = '0;
        tick(); tick();
        checks++;
        if ({result, result_valid, result_id, busy} !== 11'd0) begin
            errors++; $display("FAIL reset_outputs got=%h want=0", {result, result_valid, result_id, busy});
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_single_job();
        result_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 64'h0807060504030201; req0_mask = 8'hFF;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL single_grant got=%b want=10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (result_valid !== 1'b0) begin
                errors++; $display("FAIL single_early_valid cycle=%0d got=%b want=0", i, result_valid);
            end
        end
        tick();
        checks++;
        if ({result_valid, result, result_id, busy} !== {1'b1, 8'h24, 1'b0, 1'b1}) begin
            errors++; $display("FAIL single_result got v=%b r=%h id=%b busy=%b want v=1 r=24 id=0 busy=1",
                               result_valid, result, result_id, busy);
        end
        tick();
        checks++;
        if ({result_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL single_drop got v=%b busy=%b want 0 0", result_valid, busy);
        end
    endtask

    task automatic test_mask_wrap();
        req1_valid = 1'b1; req1_data = 64'hFFFFFFFFFFFFFFFF; req1_mask = 8'h05;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++; $display("FAIL wrap_grant got=%b want=01", {req0_ready, req1_ready});
        end
        tick();
        req1_valid = 1'b0;
        repeat (8) tick();
        checks++;
        if ({result_valid, result, result_id} !== {1'b1, 8'hFE, 1'b1}) begin
            errors++; $display("FAIL wrap_result got v=%b r=%h id=%b want v=1 r=fe id=1",
                               result_valid, result, result_id);
        end
        tick();
    endtask

    task automatic test_mask_zero();
        req0_valid = 1'b1; req0_data = 64'h1122334455667788; req0_mask = 8'h00;
        #1;
        tick();
        req0_valid = 1'b0;
        repeat (7) tick();
        checks++;
        if (result_valid !== 1'b0) begin
            errors++; $display("FAIL zero_early got=%b want=0", result_valid);
        end
        tick();
        checks++;
        if ({result_valid, result, result_id} !== {1'b1, 8'h00, 1'b0}) begin
            errors++; $display("FAIL zero_result got v=%b r=%h id=%b want v=1 r=00 id=0",
                               result_valid, result, result_id);
        end
        tick();
    endtask

    task automatic test_contention();
        int rr_ids[$];
        int fp_ids[$];
        int both_cnt = 0;
        reset = 1'b1; tick(); reset = 1'b0;
        result_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 64'h0101010101010101; req0_mask = 8'hFF;
        req1_valid = 1'b1; req1_data = 64'h0202020202020202; req1_mask = 8'hFF;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (req0_ready && req1_ready) both_cnt++;
            if (fp_req0_ready && fp_req1_ready) both_cnt++;
            if (req0_ready) rr_ids.push_back(0);
            if (req1_ready) rr_ids.push_back(1);
            if (fp_req0_ready) fp_ids.push_back(0);
            if (fp_req1_ready) fp_ids.push_back(1);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (both_cnt != 0) begin
            errors++; $display("FAIL contention_both_ready got=%0d want=0", both_cnt);
        end
        checks++;
        if (rr_ids.size() != 4) begin
            errors++; $display("FAIL rr_accept_count got=%0d want=4", rr_ids.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (rr_ids[k] != (k % 2)) begin
                    errors++; $display("FAIL rr_order job=%0d got=%0d want=%0d", k, rr_ids[k], k % 2);
                end
            end
        end
        checks++;
        if (fp_ids.size() != 4) begin
            errors++; $display("FAIL fp_accept_count got=%0d want=4", fp_ids.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (fp_ids[k] != 0) begin
                    errors++; $display("FAIL fp_order job=%0d got=%0d want=0", k, fp_ids[k]);
                end
            end
        end
        tick(); tick();
    endtask

    task automatic test_backpressure();
        int stable_bad = 0;
        int ready_bad = 0;
        reset = 1'b1; tick(); reset = 1'b0;
        result_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 64'h1010101010101010; req0_mask = 8'h0F;
        #1;
        tick();
        // Keep both requesters valid and scribble over req0 while the job is in flight.
        req1_valid = 1'b1; req1_data = 64'h0303030303030303; req1_mask = 8'hFF;
        req0_data = 64'hFFFFFFFFFFFFFFFF; req0_mask = 8'hFF;
        repeat (8) tick();
        checks++;
        if ({result_valid, result, result_id} !== {1'b1, 8'h40, 1'b0}) begin
            errors++; $display("FAIL bp_result got v=%b r=%h id=%b want v=1 r=40 id=0",
                               result_valid, result, result_id);
        end
        for (int c = 0; c < 5; c++) begin
            req0_data = req0_data ^ 64'h00FF00FF00FF00FF; req1_mask = req1_mask ^ 8'h55;
            tick();
            if ({result_valid, result, result_id} !== {1'b1, 8'h40, 1'b0}) stable_bad++;
            if (req0_ready || req1_ready) ready_bad++;
        end
        checks++;
        if (stable_bad != 0) begin
            errors++; $display("FAIL bp_stable got=%0d bad cycles want=0", stable_bad);
        end
        checks++;
        if (ready_bad != 0) begin
            errors++; $display("FAIL bp_no_accept got=%0d bad cycles want=0", ready_bad);
        end
        result_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL bp_consume_ready got=%b want=00", {req0_ready, req1_ready});
        end
        tick();
        checks++;
        if ({result_valid, req0_ready, req1_ready} !== 3'b001) begin
            errors++; $display("FAIL bp_after_consume got v=%b rdy=%b%b want v=0 rdy=01",
                               result_valid, req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        repeat (10) tick();
    endtask

    task automatic test_mid_reset();
        int seen_valid = 0;
        reset = 1'b1; tick(); reset = 1'b0;
        result_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 64'h0807060504030201; req0_mask = 8'hFF;
        #1;
        tick();
        req1_valid = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL midrst_ready got=%b want=00", {req0_ready, req1_ready});
        end
        tick();
        checks++;
        if ({result, result_valid, result_id, busy, req0_ready, req1_ready} !== 13'd0) begin
            errors++; $display("FAIL midrst_outputs got=%h want=0",
                               {result, result_valid, result_id, busy, req0_ready, req1_ready});
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL midrst_regrant got=%b want=10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (result_valid) seen_valid++;
        end
        checks++;
        if (seen_valid != 0) begin
            errors++; $display("FAIL midrst_abandon got=%0d valid cycles want=0", seen_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_mask_wrap();
        test_mask_zero();
        test_contention();
        test_backpressure();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
